// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader_if
// Brief    : Byte-stream input, control and instruction-memory write bundle
//            for the instruction loader.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       load_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       core_rst;
    logic       done;
    logic       err;

    // Host / byte source side
    modport master (
        output in_valid, in_data, load_req,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err
    );

    // Loader side
    modport slave (
        input  in_valid, in_data, load_req,
        output in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err
    );
endinterface
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Brief    : Parses framed byte stream (SYNC, BASE, LEN, payload, CHK) into
//            instruction-memory writes; holds the core in reset until a frame
//            with a good checksum has been loaded.
// Revision : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  wire logic     clk,
    input  wire logic     rst,
    instr_loader_if.slave bus
);

    localparam int unsigned c_TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    typedef enum logic [2:0] {
        S_HUNT = 3'd0,
        S_BASE = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t              r_state;
    logic [7:0]          r_ptr;
    logic [7:0]          r_cnt;
    logic [7:0]          r_acc;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                r_mem_we;
    logic [7:0]          r_mem_addr;
    logic [7:0]          r_mem_wdata;
    logic                r_core_rst;
    logic                r_done;
    logic                r_err;

    state_t              w_state;
    logic [7:0]          w_ptr;
    logic [7:0]          w_cnt;
    logic [7:0]          w_acc;
    logic [c_TO_W-1:0]   w_to_cnt;
    logic                w_mem_we;
    logic [7:0]          w_mem_addr;
    logic [7:0]          w_mem_wdata;
    logic                w_core_rst;
    logic                w_done;
    logic                w_err;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_in_frame;
    logic [7:0]          w_sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_HUNT;
            r_ptr       <= 8'd0;
            r_cnt       <= 8'd0;
            r_acc       <= 8'd0;
            r_to_cnt    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 8'd0;
            r_mem_wdata <= 8'd0;
            r_core_rst  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ptr       <= w_ptr;
            r_cnt       <= w_cnt;
            r_acc       <= w_acc;
            r_to_cnt    <= w_to_cnt;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_core_rst  <= w_core_rst;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_ptr       = r_ptr;
        w_cnt       = r_cnt;
        w_acc       = r_acc;
        w_to_cnt    = r_to_cnt;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_core_rst  = r_core_rst;
        w_done      = r_done;
        w_err       = r_err;

        w_in_ready = (r_state != S_DONE) && (r_state != S_ERR);
        w_accept   = bus.in_valid && w_in_ready;
        w_in_frame = (r_state == S_BASE) || (r_state == S_LEN) ||
                     (r_state == S_DATA) || (r_state == S_CHK);
        w_sum      = r_acc + bus.in_data;

        // Idle counter only runs between bytes of a frame in progress
        if (w_in_frame) begin
            if (w_accept) begin
                w_to_cnt = '0;
            end else if (TIMEOUT != 0) begin
                w_to_cnt = r_to_cnt + c_TO_ONE;
            end
        end

        case (r_state)
            S_HUNT: begin
                if (w_accept && (bus.in_data == SYNC_BYTE)) begin
                    w_state  = S_BASE;
                    w_acc    = 8'd0;
                    w_err    = 1'b0;
                    w_to_cnt = '0;
                end
            end
            S_BASE: begin
                if (w_accept) begin
                    w_ptr   = bus.in_data;
                    w_acc   = bus.in_data;
                    w_state = S_LEN;
                end
            end
            S_LEN: begin
                if (w_accept) begin
                    w_cnt   = bus.in_data;
                    w_acc   = w_sum;
                    w_state = (bus.in_data == 8'd0) ? S_CHK : S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_acc       = w_sum;
                    w_mem_we    = 1'b1;
                    w_mem_addr  = r_ptr;
                    w_mem_wdata = bus.in_data;
                    w_ptr       = r_ptr + 8'd1;
                    w_cnt       = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        w_state = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    w_acc = w_sum;
                    if (w_sum == 8'd0) begin
                        w_state    = S_DONE;
                        w_done     = 1'b1;
                        w_core_rst = 1'b0;
                    end else begin
                        w_state = S_ERR;
                        w_err   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.load_req) begin
                    w_state    = S_HUNT;
                    w_done     = 1'b0;
                    w_core_rst = 1'b1;
                end
            end
            S_ERR: begin
                // err deliberately persists until the next SYNC is accepted
                if (bus.load_req) begin
                    w_state = S_HUNT;
                end
            end
            default: begin
                w_state = S_HUNT;
            end
        endcase

        // Abort on the idle edge that would bring the counter to TIMEOUT
        if ((TIMEOUT != 0) && w_in_frame && !w_accept && (r_to_cnt == c_TO_LAST)) begin
            w_state  = S_ERR;
            w_err    = 1'b1;
            w_to_cnt = '0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.core_rst  = r_core_rst;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_loader
// Brief    : Scoreboard bench for instr_loader: directed and random frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        int unsigned due;
        logic [7:0]  addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        int unsigned due;
        logic        done;
        logic        err;
        logic        core_rst;
    } oc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned pcnt = 0;
    wr_t         wq[$];
    oc_t         oq[$];

    instr_loader_if bus();

    instr_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, pcnt);
        end
    endtask

    // Monitor: compares writes and frame outcomes at the negedge they are due
    always @(negedge clk) begin : monitor
        wr_t w;
        oc_t o;
        if (bus.mem_we === 1'b1) begin
            if (wq.size() == 0) begin
                check("unexpected_write", {31'd0, bus.mem_we}, 32'd0);
            end else begin
                w = wq.pop_front();
                check("write_cycle", pcnt, w.due);
                check("write_addr", {24'd0, bus.mem_addr}, {24'd0, w.addr});
                check("write_data", {24'd0, bus.mem_wdata}, {24'd0, w.data});
            end
        end else if (wq.size() != 0 && wq[0].due <= pcnt) begin
            w = wq.pop_front();
            check("missing_write", {31'd0, bus.mem_we}, 32'd1);
        end
        if (oq.size() != 0 && oq[0].due <= pcnt) begin
            o = oq.pop_front();
            check("outcome_cycle", pcnt, o.due);
            check("outcome_done", {31'd0, bus.done}, {31'd0, o.done});
            check("outcome_err", {31'd0, bus.err}, {31'd0, o.err});
            check("outcome_core_rst", {31'd0, bus.core_rst}, {31'd0, o.core_rst});
        end
    end

    // Called at a negedge; presents one byte after a random gap, records expectations
    task automatic send_byte(input logic [7:0] b, input int maxgap, input bit rq,
                             input bit is_wr, input logic [7:0] wr_addr,
                             input bit is_chk, input bit good);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        bus.in_valid = 1'b0;
        bus.load_req = 1'b0;
        repeat (g) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.load_req = rq;
        if (is_wr)  wq.push_back('{pcnt + 1, wr_addr, b});
        if (is_chk) oq.push_back('{pcnt + 1, good, !good, !good});
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.load_req = 1'b0;
    endtask

    // fr = BASE, LEN, payload..., CHK; validity judged from the byte sum alone
    task automatic send_frame(input byte_q_t garb, input byte_q_t fr, input int maxgap,
                              input bit rnd_req, output bit good);
        int sum;
        int last;
        bit rq;
        sum  = 0;
        last = fr.size() - 1;
        foreach (fr[i]) sum += int'(fr[i]);
        good = ((sum % 256) == 0);
        foreach (garb[i]) send_byte(garb[i], maxgap, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        send_byte(8'hA5, maxgap, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i <= last; i++) begin
            rq = rnd_req && (i >= 2) && (i < last) && ($urandom_range(3, 0) == 0);
            send_byte(fr[i], maxgap, rq, (i >= 2) && (i < last),
                      8'((int'(fr[0]) + i - 2) % 256), i == last, good);
        end
    endtask

    task automatic wait_outcome();
        int k;
        k = 0;
        while (oq.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (oq.size() != 0) begin
            check("outcome_wait_expired", oq.size(), 0);
            oq.delete();
        end
    endtask

    task automatic pulse_load();
        bus.load_req = 1'b1;
        @(negedge clk);
        bus.load_req = 1'b0;
    endtask

    // Frame end: DONE/ERR must stall input, then load_req returns to HUNT
    task automatic close_frame(input bit good);
        wait_outcome();
        check("in_ready_held_low", {31'd0, bus.in_ready}, 32'd0);
        pulse_load();
        check("in_ready_after_load", {31'd0, bus.in_ready}, 32'd1);
        check("core_rst_after_load", {31'd0, bus.core_rst}, 32'd1);
        check("done_after_load", {31'd0, bus.done}, 32'd0);
        check("err_kept_after_load", {31'd0, bus.err}, {31'd0, !good});
    endtask

    task automatic run_frame(input byte_q_t garb, input byte_q_t fr, input int maxgap, input bit rnd_req);
        bit good;
        send_frame(garb, fr, maxgap, rnd_req, good);
        close_frame(good);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        byte_q_t garb;
        byte_q_t fr;
        int      len;
        int      sum;
        logic [7:0] b;
        bit      good;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        bus.load_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        check("rst_core_rst", {31'd0, bus.core_rst}, 32'd1);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        garb = {};
        run_frame(garb, '{8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87}, 0, 1'b0);
        run_frame(garb, '{8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF9}, 3, 1'b0);
        run_frame(garb, '{8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h88}, 0, 1'b0);
        run_frame(garb, '{8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87}, 1, 1'b0);
        run_frame('{8'h00, 8'hFF, 8'h5A}, '{8'h20, 8'h00, 8'hE0}, 0, 1'b0);

        // Idle timeout inside DATA: one write, then ERR after 8 idle edges
        send_byte(8'hA5, 0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        send_byte(8'h10, 0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        send_byte(8'h03, 0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        send_byte(8'h11, 0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        check("timeout_err_early", {31'd0, bus.err}, 32'd0);
        @(negedge clk);
        check("timeout_err", {31'd0, bus.err}, 32'd1);
        check("timeout_core_rst", {31'd0, bus.core_rst}, 32'd1);
        check("timeout_done", {31'd0, bus.done}, 32'd0);
        check("timeout_in_ready", {31'd0, bus.in_ready}, 32'd0);
        repeat (4) @(negedge clk);
        check("timeout_single_write", wq.size(), 0);
        pulse_load();

        // Reset mid-frame, then a complete frame
        send_byte(8'hA5, 0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        send_byte(8'h10, 0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        send_byte(8'h03, 0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        send_byte(8'h11, 0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("midrst_core_rst", {31'd0, bus.core_rst}, 32'd1);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_err", {31'd0, bus.err}, 32'd0);
        check("midrst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        run_frame(garb, '{8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87}, 0, 1'b0);

        // Random frames with gaps, garbage prefix and stray load_req pulses
        for (int n = 0; n < 30; n++) begin
            garb = {};
            repeat ($urandom_range(3, 0)) begin
                b = 8'($urandom_range(255, 0));
                if (b == 8'hA5) b = 8'h00;
                garb.push_back(b);
            end
            fr = {};
            fr.push_back(8'($urandom_range(255, 0)));
            len = int'($urandom_range(12, 0));
            fr.push_back(8'(len));
            sum = int'(fr[0]) + len;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(255, 0));
                fr.push_back(b);
                sum += int'(b);
            end
            b = 8'((256 - (sum % 256)) % 256);
            if ($urandom_range(3, 0) == 0) b = b + 8'($urandom_range(255, 1));
            fr.push_back(b);
            send_frame(garb, fr, 3, 1'b1, good);
            close_frame(good);
        end

        repeat (3) @(negedge clk);
        check("write_queue_drained", wq.size(), 0);
        check("outcome_queue_drained", oq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Write-side counterpart to the instruction fetch path: receives a framed byte stream and writes 8-bit instructions into instruction memory through its write port.
- Holds the core in reset (core_rst=1) while loading and releases it only after a frame passes its checksum.
- Sits between the host/debug byte source and the instruction memory write port. The fetch unit reads the same memory once core_rst drops.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1000, maximum idle cycles between bytes inside a frame before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  byte source has in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- load_req  input  1  one-cycle pulse; restart loading from DONE or ERR.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  8  write address.
- mem_wdata  output  8  instruction byte.
- core_rst  output  1  active-high reset to core/fetch; 1 = hold core.
- done  output  1  valid image loaded.
- err  output  1  last frame failed (checksum or timeout).

Behaviour:
- Reset (rst=0 at posedge):
  - state=HUNT, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, done=0, err=0.
  - Checksum accumulator, counters and timeout counter cleared.
  - Reset mid-frame abandons the frame; words already written remain in memory.
- Accept: a byte is accepted on a posedge where in_valid=1 and in_ready=1. in_ready=1 in HUNT, BASE, LEN, DATA and CHK; in_ready=0 in DONE and ERR.
- Frame format: SYNC_BYTE, BASE, LEN, LEN payload bytes, CHK.
  - Valid frame: (BASE + LEN + all payload + CHK) mod 256 == 0.
- States:
  - HUNT: accepted bytes other than SYNC_BYTE are discarded. SYNC_BYTE goes to BASE, clears the accumulator and clears err.
  - BASE: the accepted byte loads the address pointer and the accumulator, then goes to LEN.
  - LEN: the accepted byte loads the remaining count and is added to the accumulator. LEN=0 goes to CHK; otherwise goes to DATA.
  - DATA: each accepted byte is added to the accumulator. The pointer increments mod 256 (0xFF wraps to 0x00) and the count decrements. The state goes to CHK when the count reaches 0.
  - CHK:
    - The accepted byte is added to the accumulator.
    - Sum 0 goes to DONE, with done=1 and core_rst=0 from the next cycle.
    - Nonzero sum goes to ERR, with err=1; core_rst stays 1 and done stays 0.
  - DONE: holds until a load_req pulse, which clears done, sets core_rst=1 and goes to HUNT.
  - ERR: holds (err=1) until load_req, which goes to HUNT. err stays set until the next SYNC_BYTE is accepted.
- Write timing:
  - A payload byte accepted at edge N gives mem_we=1 for exactly the cycle after N.
  - During that cycle mem_addr = BASE + index and mem_wdata = byte. All three signals are registered.
  - mem_we=0 in all other cycles; mem_addr and mem_wdata hold their last values.
  - Back-to-back payload bytes produce back-to-back write strobes.
- Timeout:
  - Active in BASE, LEN, DATA and CHK when TIMEOUT>0.
  - The counter resets on each accepted byte and increments on each cycle without one.
  - When it reaches TIMEOUT the state goes to ERR with err=1, and no further writes occur.
- load_req outside DONE or ERR is ignored.
- core_rst is only ever cleared on the CHK→DONE transition.

Test Plan:
- Basic frame: A5,10,03,11,22,33,87 with no gaps → writes (0x10,0x11),(0x11,0x22),(0x12,0x33), each mem_we one cycle after its accepting edge; then done=1, core_rst=0, err=0.
- Address wrap with in_valid gaps of 0–3 cycles: A5,FE,03,01,02,03,F9 → writes at 0xFE,0xFF,0x00; done=1.
- Bad checksum: A5,10,03,11,22,33,88 → three writes occur, then err=1, done=0, core_rst=1, in_ready=0; a load_req pulse returns to HUNT, and a following good frame gives done=1 and err=0.
- Garbage then zero-length frame: 00,FF,5A,A5,20,00,E0 → no writes, done=1.
- Timeout: with TIMEOUT=8, send A5,10,03,11 then idle 8 cycles → err=1 on the 8th idle cycle, one write only, core_rst=1.
- Reset mid-frame: drive rst=0 for one cycle after A5,10,03,11 → next cycle shows state HUNT, core_rst=1, done=0, err=0, mem_we=0; a fresh basic frame completes normally.
